// File: rtl/right_shift_if.sv
// right_shift_if: request/response bundle between an ALU sequencer and the right shifter
interface right_shift_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] A;
  logic [31:0] B;
  logic arith;
  logic ready;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  modport master (output start, A, B, arith, input ready, busy, done, result);
  modport slave (input start, A, B, arith, output ready, busy, done, result);
endinterface

// File: rtl/right_shift_unit.sv
// right_shift_unit: multi-cycle logical/arithmetic right shifter, one binary stage per cycle
module right_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input logic clk,
  input logic rst,
  right_shift_if.slave bus
);
  localparam int CW = $clog2(SHW);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [SHW-1:0] amt;
  logic oor, fill, last, accept;
  logic [SHW:0] sh;
  logic [WIDTH-1:0] work, shifted, staged, result;
  assign sh = (SHW+1)'(1) << cnt;
  // fill is pre-masked with arith, so the top sh bits come from it directly
  assign shifted = (work >> sh) | (fill ? ~({WIDTH{1'b1}} >> sh) : '0);
  assign staged = amt[cnt] ? shifted : work;
  assign last = cnt == CW'(SHW - 1);
  assign accept = bus.start && bus.ready;
  assign bus.ready = state != SHIFT;
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  assign bus.result = result;
  always_comb begin
    next = state;
    next = state == SHIFT ? (last ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      amt <= '0;
      oor <= 1'b0;
      fill <= 1'b0;
      work <= '0;
      result <= '0;
    end else if (accept) begin
      cnt <= '0;
      amt <= bus.B[SHW-1:0];
      oor <= |bus.B[31:SHW];
      fill <= bus.arith & bus.A[WIDTH-1];
      work <= bus.A;
    end else if (state == SHIFT) begin
      cnt <= cnt + 1'b1;
      work <= staged;
      if (last) result <= oor ? {WIDTH{fill}} : staged;
    end
  end
endmodule
